irq_controller: RTL

//  Interrupt consumer for the peripheral interrupt lines, including the timer's timer_State.

---
 rtl/irq_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// irq_controller: rising-edge interrupt capture, mask, fixed priority and ack/eret handshake to the CPU.
// Optional macro IRQ_SYNC_EN inserts a 2-flop synchroniser ahead of edge capture.
module irq_controller #(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic [1:0]         rd_addr,
  output logic [31:0]        rd_data,
  output logic               cpu_irq,
  output logic [2:0]         irq_id,
  input  logic               cpu_ack,
  input  logic               cpu_eret
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_irq;
  logic               w_irq_nxt;
  logic [2:0]         r_id;
  logic [2:0]         w_id_nxt;
  logic               w_ack_take;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_src_d;
  logic [NUM_SRC-1:0] w_src;
  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_active;
  logic [NUM_SRC-1:0] w_id_onehot;
  logic               w_id_active;
  logic [2:0]         w_sel;
  logic               w_unused_wr;

  assign w_unused_wr = ^wr_data[31:NUM_SRC];

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] r_sync1;
  logic [NUM_SRC-1:0] r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = irq_src;
`endif

  assign w_edge   = w_src & ~r_src_d;
  assign w_active = r_pend & r_mask;

  // Decode of the latched id, used for the withdraw test and the ack clear
  always_comb begin
    w_id_onehot = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (3'(i) == r_id) w_id_onehot[i] = 1'b1;
    end
  end

  assign w_id_active = |(w_active & w_id_onehot);

  // Lowest active index wins
  always_comb begin
    w_sel = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (w_active[i]) w_sel = 3'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_irq_nxt   = r_irq;
    w_id_nxt    = r_id;
    w_ack_take  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_active) begin
          w_state_nxt = S_REQ;
          w_irq_nxt   = 1'b1;
          w_id_nxt    = w_sel;
        end
      end
      S_REQ: begin
        if (cpu_ack) begin
          w_state_nxt = S_SERVICE;
          w_irq_nxt   = 1'b0;
          w_ack_take  = 1'b1;
        end else if (!w_id_active) begin
          w_state_nxt = S_IDLE;
          w_irq_nxt   = 1'b0;
        end
      end
      S_SERVICE: begin
        if (cpu_eret) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_irq_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_irq   <= 1'b0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= w_irq_nxt;
      r_id    <= w_id_nxt;
    end
  end

  assign w_clr = ((wr_en && (wr_addr == 2'd1)) ? wr_data[NUM_SRC-1:0] : '0)
               | (w_ack_take ? w_id_onehot : '0);

  // New edges take priority over a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask  <= '0;
      r_pend  <= '0;
      r_src_d <= '0;
    end else begin
      r_src_d <= w_src;
      r_pend  <= w_edge | (r_pend & ~w_clr);
      if (wr_en && (wr_addr == 2'd0)) r_mask <= wr_data[NUM_SRC-1:0];
    end
  end

  always_comb begin
    case (rd_addr)
      2'd0:    rd_data = 32'(r_mask);
      2'd1:    rd_data = 32'(r_pend);
      2'd2:    rd_data = {27'b0, r_id, r_state};
      default: rd_data = '0;
    endcase
  end

  assign cpu_irq = r_irq;
  assign irq_id  = r_id;

endmodule
